fp8_operand_sequencer: RTL and testbench

Front-end sequencer for the 8-bit floating-point multiplier. It loads operand A and then operand B over the shared 8-bit input bus, with each load triggered by a strobe pin that is asynchronous to the clock. It then issues one start pulse to the multiplier core, waits for the core's done signal (bounded by a timeout), and holds the product on the output bus with a valid flag. It sits between the pad-level inputs and the multiplier core, and drives the output bus.

---
 rtl/fp8_operand_sequencer_if.sv | 26 ++
 rtl/fp8_operand_sequencer.sv | 104 ++++++++++
 tb/tb_fp8_operand_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/fp8_operand_sequencer_if.sv
// Bundle of pad-side, core-side and result signals around the FP8 operand
// sequencer. master = environment (pads + multiplier core), slave = sequencer.
interface fp8_operand_sequencer_if;
  logic [7:0] in_data;
  logic       in_strobe;
  logic       core_done;
  logic [7:0] core_result;
  logic [7:0] core_a;
  logic [7:0] core_b;
  logic       core_start;
  logic [7:0] out_data;
  logic       out_valid;
  logic       err;
  logic       busy;
  logic       expect_b;

  modport master (
    output in_data, in_strobe, core_done, core_result,
    input  core_a, core_b, core_start, out_data, out_valid, err, busy, expect_b
  );

  modport slave (
    input  in_data, in_strobe, core_done, core_result,
    output core_a, core_b, core_start, out_data, out_valid, err, busy, expect_b
  );
endinterface

// File: rtl/fp8_operand_sequencer.sv
// FP8 operand sequencer: loads A then B on rising edges of an asynchronous
// strobe, pulses core_start once, waits for core_done with a timeout and
// holds the product (or 8'hFF on timeout) on out_data.
module fp8_operand_sequencer #(
  parameter int unsigned TIMEOUT     = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                   clk,
  input logic                   rst,
  fp8_operand_sequencer_if.slave bus
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD_B = 2'd1;
  localparam logic [1:0] S_ISSUE  = 2'd2;
  localparam logic [1:0] S_WAIT   = 2'd3;

  logic [1:0]             state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   strobe_edge;
  logic [TW-1:0]          timer;
  logic [7:0]             core_a_q;
  logic [7:0]             core_b_q;
  logic [7:0]             out_data_q;
  logic                   out_valid_q;
  logic                   err_q;

  // Synchronise the pad strobe and remember the last synchronised level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], bus.in_strobe};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign strobe_edge = sync[SYNC_STAGES-1] & ~prev;

  // Operand capture, issue, completion/timeout sequencing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      timer       <= '0;
      core_a_q    <= '0;
      core_b_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (strobe_edge) begin
            core_a_q    <= bus.in_data;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            state       <= S_LOAD_B;
          end
        end
        S_LOAD_B: begin
          if (strobe_edge) begin
            core_b_q <= bus.in_data;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // done is checked first so it wins over a simultaneous timeout
          if (bus.core_done) begin
            out_data_q  <= bus.core_result;
            out_valid_q <= 1'b1;
            state       <= S_IDLE;
          end else if (timer == TIMER_LAST) begin
            out_data_q  <= 8'hFF;
            err_q       <= 1'b1;
            out_valid_q <= 1'b0;
            state       <= S_IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.core_a     = core_a_q;
  assign bus.core_b     = core_b_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.err        = err_q;
  assign bus.core_start = (state == S_ISSUE);
  assign bus.busy       = (state == S_ISSUE) || (state == S_WAIT);
  assign bus.expect_b   = (state == S_LOAD_B);

endmodule

// File: tb/tb_fp8_operand_sequencer.sv
// Randomised bench for fp8_operand_sequencer with a transaction-level model:
// each operation's outcome is derived from its done delay versus TIMEOUT.
module tb_fp8_operand_sequencer;

  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned SYNC    = 2;

  logic clk    = 1'b0;
  logic rst    = 1'b0;
  logic clk_en = 1'b0;

  fp8_operand_sequencer_if bus();

  fp8_operand_sequencer #(
    .TIMEOUT    (TIMEOUT),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Gated clock so reset can be exercised with no clock running
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;
  int starts   = 0;
  int eb_rises = 0;
  logic eb_q   = 1'b0;
  logic [7:0] exp_out = 8'h00;

  // Count start pulses and rising edges of expect_b
  always @(negedge clk) begin
    if (bus.core_start === 1'b1) starts <= starts + 1;
    if (bus.expect_b === 1'b1 && !eb_q) eb_rises <= eb_rises + 1;
    eb_q <= (bus.expect_b === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int i = 0;
    while ((bus.busy !== 1'b0 || bus.expect_b !== 1'b0) && i < 60) begin
      @(negedge clk);
      i++;
    end
    if (i == 60) check("idle_wait", i, 0);
  endtask

  task automatic load_a(input logic [7:0] a, input int hold);
    @(posedge clk); #2;
    bus.in_data   = a;
    bus.in_strobe = 1'b1;
    for (int j = 1; j <= hold + 4; j++) begin
      @(posedge clk); #2;
      if (j == hold) bus.in_strobe = 1'b0;
      @(negedge clk); #1;
      if (j <= 3) check("a_latency", bus.expect_b, (j == 3));
    end
    check("core_a", bus.core_a, a);
    check("a_clears_valid", bus.out_valid, 0);
    check("a_clears_err", bus.err, 0);
    check("out_data_held", bus.out_data, exp_out);
    check("expect_b_high", bus.expect_b, 1);
  endtask

  task automatic load_b(input logic [7:0] b, input int hb, output bit ok);
    ok = 1'b0;
    @(posedge clk); #2;
    bus.in_data   = b;
    bus.in_strobe = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      @(posedge clk); #2;
      if (j == hb) bus.in_strobe = 1'b0;
      @(negedge clk);
      if (bus.core_start === 1'b1) begin
        check("start_latency", j, 3);
        check("core_b", bus.core_b, b);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      bus.in_strobe = 1'b0;
      check("start_seen", 0, 1);
    end
  endtask

  // Called at the negedge inside the start cycle
  task automatic finish_op(input logic [7:0] a, input logic [7:0] b, input int n,
                           input logic [7:0] res, input bit inj_issue, input bit inj_wait);
    int m;
    logic ev, ee;
    m = (n <= int'(TIMEOUT)) ? n : int'(TIMEOUT);
    bus.core_done   = inj_issue;
    bus.core_result = ~res;
    for (int i = 1; i <= m; i++) begin
      @(posedge clk); #2;
      bus.core_done   = (i == n);
      bus.core_result = res;
      if (inj_wait && i == 1) begin
        bus.in_data   = ~b;
        bus.in_strobe = 1'b1;
      end
      if (inj_wait && i == 2) bus.in_strobe = 1'b0;
      @(negedge clk); #1;
      if (i == m) check("busy_before_end", bus.busy, 1);
    end
    @(posedge clk); #2;
    bus.core_done = 1'b0;
    @(negedge clk); #1;
    if (n <= int'(TIMEOUT)) begin
      exp_out = res; ev = 1'b1; ee = 1'b0;
    end else begin
      exp_out = 8'hFF; ev = 1'b0; ee = 1'b1;
    end
    check("busy_after_end", bus.busy, 0);
    check("expect_b_after", bus.expect_b, 0);
    check("out_data", bus.out_data, exp_out);
    check("out_valid", bus.out_valid, ev);
    check("err", bus.err, ee);
    check("core_a_held", bus.core_a, a);
    check("core_b_held", bus.core_b, b);
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int n,
                       input logic [7:0] res, input int hold, input int hb,
                       input bit inj_issue, input bit inj_wait);
    int s0, r0;
    bit ok;
    wait_idle();
    s0 = starts;
    r0 = eb_rises;
    load_a(a, hold);
    load_b(b, hb, ok);
    if (ok) finish_op(a, b, n, res, inj_issue, inj_wait);
    check("start_count", starts - s0, 1);
    check("expect_b_rises", eb_rises - r0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m;
    bit ok, inj_w;
    int s1;
    bus.in_data     = 8'h00;
    bus.in_strobe   = 1'b0;
    bus.core_done   = 1'b0;
    bus.core_result = 8'h00;

    // Reset with no clock running
    #2 rst = 1'b1;
    #2;
    check("reset_outputs",
          {bus.core_a, bus.core_b, bus.out_data, bus.core_start,
           bus.out_valid, bus.err, bus.busy, bus.expect_b}, 0);
    #2 rst = 1'b0;
    clk_en = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("post_reset_expect_b", bus.expect_b, 0);
    check("post_reset_busy", bus.busy, 0);
    check("post_reset_valid", bus.out_valid, 0);

    // Nominal, strobe held 10 cycles with ISSUE-done and WAIT strobes,
    // timeout, recovery after timeout, collision
    do_op(8'h38, 8'h40, 3, 8'h40, 2, 2, 1'b0, 1'b0);
    do_op(8'hA5, 8'h3C, 6, 8'h99, 10, 3, 1'b1, 1'b1);
    do_op(8'h12, 8'h34, 1000, 8'h00, 1, 1, 1'b0, 1'b1);
    do_op(8'h56, 8'h78, 2, 8'hC3, 3, 1, 1'b0, 1'b0);
    do_op(8'h21, 8'h43, 16, 8'h5A, 1, 2, 1'b1, 1'b1);

    // Async reset mid-WAIT
    wait_idle();
    load_a(8'h11, 2);
    load_b(8'h22, 1, ok);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_midwait_outputs",
          {bus.core_a, bus.core_b, bus.out_data, bus.core_start,
           bus.out_valid, bus.err, bus.busy, bus.expect_b}, 0);
    @(posedge clk); #3 rst = 1'b0;
    exp_out = 8'h00;
    s1 = starts;
    bus.core_done   = 1'b1;
    bus.core_result = 8'h77;
    repeat (4) @(negedge clk);
    #1;
    check("late_done_no_valid", bus.out_valid, 0);
    check("late_done_no_data", bus.out_data, 0);
    check("late_done_idle", bus.busy, 0);
    check("no_start_after_rst", starts - s1, 0);
    bus.core_done = 1'b0;

    // Randomised operations
    for (int k = 0; k < 10; k++) begin
      n = $urandom_range(1, 20);
      m = (n <= int'(TIMEOUT)) ? n : int'(TIMEOUT);
      inj_w = (m >= 5) && ($urandom_range(0, 1) == 1);
      do_op(8'($urandom), 8'($urandom), n, 8'($urandom),
            $urandom_range(1, 10), $urandom_range(1, 3),
            1'($urandom_range(0, 1)), inj_w);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
